// File: rtl/descriptor_bank.sv
// -----------------------------------------------------------------------------
// descriptor_bank
//   Descriptor store for the matching stage. Descriptors are appended in order
//   through a valid/ready write port, and occupancy is tracked. A scan engine
//   streams every stored entry to the distance unit over a valid/ready stream.
//   A random-access read port serves debug and readback.
//
// Parameters
//   DATA_WIDTH : descriptor width in bits
//   ADDR_WIDTH : entry address width, depth = 2**ADDR_WIDTH
//   READ_REG   : 0 = combinational reads, 1 = registered reads (1-cycle latency)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous occupancy clear, aborts a running scan
//   wr_valid/wr_ready   append handshake, wr_data = descriptor
//   count/full/empty    occupancy status
//   rd_addr/rd_data     random read port
//   scan_start          single-cycle request to stream all entries
//   scan_busy           scan engine not idle
//   out_valid/out_ready stream handshake; out_data/out_index/out_last per beat
//   scan_done           one-cycle pulse when a scan completes
// -----------------------------------------------------------------------------
module descriptor_bank #(
    parameter int DATA_WIDTH = 1280,
    parameter int ADDR_WIDTH = 5,
    parameter bit READ_REG   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  scan_start,
    output logic                  scan_busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic                  scan_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_STREAM,
        ST_DONE
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_count;
    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH-1:0] w_idx_next;
    logic [ADDR_WIDTH:0]   r_snap;
    logic [ADDR_WIDTH:0]   w_snap_next;
    logic                  w_wr_fire;
    logic                  w_last;

    // ---------------------------------------------------------------- occupancy
    // count never exceeds DEPTH, so its MSB alone marks the full condition.
    assign full      = r_count[ADDR_WIDTH];
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign wr_ready  = !full && !clr;
    assign w_wr_fire = wr_valid && wr_ready;

    // NOTE: the storage array has no reset; clearing 32 wide words would cost a
    // reset network on every bit and occupancy already says what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_count[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (w_wr_fire) begin
            r_count <= r_count + (ADDR_WIDTH + 1)'(1);
        end
    end

    // ---------------------------------------------------------------- scan FSM
    // snap is never zero while streaming, so snap-1 cannot underflow here.
    assign w_last = ({1'b0, r_idx} == (r_snap - (ADDR_WIDTH + 1)'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_snap  <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_snap  <= w_snap_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_snap_next  = r_snap;
        case (r_state)
            ST_IDLE: begin
                if (scan_start) begin
                    // The snapshot freezes the scan length; later appends are
                    // stored but not streamed by this scan.
                    w_snap_next = r_count;
                    w_idx_next  = '0;
                    if (r_count == '0) begin
                        w_state_next = ST_DONE;
                    end else if (READ_REG) begin
                        w_state_next = ST_FETCH;
                    end else begin
                        w_state_next = ST_STREAM;
                    end
                end
            end
            ST_FETCH: begin
                w_state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (out_ready) begin
                    if (w_last) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_idx_next   = r_idx + ADDR_WIDTH'(1);
                        w_state_next = READ_REG ? ST_FETCH : ST_STREAM;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // Clear aborts silently: straight to idle, no completion pulse.
        if (clr) begin
            w_state_next = ST_IDLE;
        end
    end

    assign scan_busy = (r_state != ST_IDLE);
    assign out_valid = (r_state == ST_STREAM);
    assign out_last  = (r_state == ST_STREAM) && w_last;
    assign out_index = r_idx;
    assign scan_done = (r_state == ST_DONE);

    // ---------------------------------------------------------------- read paths
    if (READ_REG) begin : g_reg_read
        logic [DATA_WIDTH-1:0] r_rd_data;
        logic [DATA_WIDTH-1:0] r_out_data;

        // Reads sample the array before this edge's write lands, giving
        // read-before-write behaviour on an address collision.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rd_data  <= '0;
                r_out_data <= '0;
            end else begin
                r_rd_data <= r_mem[rd_addr];
                if (r_state == ST_FETCH) begin
                    r_out_data <= r_mem[r_idx];
                end
            end
        end

        assign rd_data  = r_rd_data;
        assign out_data = r_out_data;
    end else begin : g_comb_read
        assign rd_data  = r_mem[rd_addr];
        // Entries below snap are never rewritten during a scan, so this stays
        // stable while a beat is stalled.
        assign out_data = r_mem[r_idx];
    end

endmodule

// File: doc/descriptor_bank.md
Name: descriptor_bank

Overview:
- Parametrised descriptor store for the matching stage. Generalises the single-port 1280-bit x 32 descriptor RAM.
- Accepts descriptors in append order through a valid/ready write port and tracks occupancy.
- Streams all stored descriptors to the distance unit through a scan engine with a valid/ready handshake.
- Keeps a random-access read port for debug and readback. Read path is selectable: combinational or registered.

Parameters:
- DATA_WIDTH, 1280, descriptor width in bits.
- ADDR_WIDTH, 5, entry address width; depth is 2**ADDR_WIDTH.
- READ_REG, 0, 0 = combinational read, 1 = registered read (1-cycle latency).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear of occupancy; aborts any scan in progress.
- wr_valid  in  1  write request.
- wr_data  in  DATA_WIDTH  descriptor to append.
- wr_ready  out  1  high when not full and clr is low.
- count  out  ADDR_WIDTH+1  number of stored entries.
- full  out  1  count == 2**ADDR_WIDTH.
- empty  out  1  count == 0.
- rd_addr  in  ADDR_WIDTH  random read address.
- rd_data  out  DATA_WIDTH  random read data.
- scan_start  in  1  single-cycle request to stream all entries.
- scan_busy  out  1  scan engine not IDLE.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  stream descriptor.
- out_index  out  ADDR_WIDTH  address of the current beat.
- out_last  out  1  current beat is the final entry.
- scan_done  out  1  one-cycle pulse when a scan completes.

Behaviour:
- Reset (rst_n low, async) sets:
  - count=0, state IDLE, out_valid=0, out_last=0, scan_done=0, out_index=0.
  - Registered out_data and rd_data = 0.
  - Memory contents are not reset.
- Write:
  - A beat is accepted when wr_valid && wr_ready.
  - Accepted data goes to ram[count[ADDR_WIDTH-1:0]] and count increments.
  - When full, wr_ready=0 and wr_valid is ignored; there is no wrap-around.
- clr:
  - count goes to 0 next cycle. clr takes priority over a same-cycle write; that write is dropped because wr_ready is low.
  - Memory is not erased.
- Random read:
  - READ_REG=0: rd_data=ram[rd_addr] combinationally. A same-address write is visible after the write edge.
  - READ_REG=1: rd_data is registered, 1-cycle latency, read-before-write (returns old data on a same-cycle collision).
  - Addresses >= count return stale contents; this is not flagged.
- Scan FSM states: IDLE, FETCH (used only when READ_REG=1), STREAM, DONE.
- IDLE:
  - On scan_start: snap = count and idx = 0.
  - If snap == 0, go to DONE. Otherwise go to STREAM (READ_REG=0) or FETCH (READ_REG=1).
  - scan_start outside IDLE is ignored.
- FETCH: out_data register <= ram[idx]; go to STREAM next cycle.
- STREAM:
  - out_valid=1, out_index=idx, out_last=(idx==snap-1).
  - READ_REG=0: out_data=ram[idx] combinationally.
  - out_data and out_index stay stable while out_ready is low.
  - On handshake with out_last set, go to DONE.
  - On handshake without out_last, idx++ and stay in STREAM (READ_REG=0) or go to FETCH (READ_REG=1).
- Throughput: 1 beat/cycle for READ_REG=0; 1 beat per 2 cycles for READ_REG=1.
- DONE: scan_done=1 for exactly one cycle, then IDLE. scan_busy is low only in IDLE.
- Writes during a scan:
  - Allowed. They land at addresses >= snap.
  - They do not extend the current scan.
- clr during a scan:
  - The FSM returns to IDLE next cycle and out_valid drops.
  - No scan_done pulse.
  - A beat presented in the clr cycle counts as transferred only if out_ready was high in that cycle.
- Reset mid-scan: immediate IDLE with outputs at reset values.

Test Plan:
- Write 3 descriptors (A, B, C), then scan with out_ready=1, READ_REG=0 -> beats A/B/C on consecutive cycles, out_index 0,1,2, out_last on C only, scan_done pulses the cycle after C, count=3.
- Fill all 32 entries with wr_valid held high and write a 33rd -> wr_ready=0 after 32 accepts, full=1, count=32, entry 0 unchanged.
- READ_REG=1, 2 entries, out_ready toggling 1,0,1 -> out_valid low in FETCH cycles, data stable while stalled, 2 beats delivered, then scan_done.
- scan_start with count=0 -> scan_busy high for one cycle, scan_done pulses, no out_valid.
- Scan of 4 entries with a write during beat 1 and clr asserted at beat 2 -> beat 2 is transferred only if out_ready was high in that cycle, no further beats, no scan_done, count=0 next cycle.
- rst_n low mid-scan, async (between edges) -> out_valid, scan_busy and count drop at once; after release, a rewrite and rescan behaves as a fresh block.
